switch_input_port: RTL and testbench

- Input-side peripheral that presents the 8 board switches to the CPU as a readable I/O port.
- It is the device end of the CPU's switch-read interface, the counterpart to the CPU's LED write port.
- Synchronises and debounces raw `swiches` into a stable value and flags each new value as pending.
- The CPU reads the value with a one-cycle strobe that returns the data and clears the pending and overrun flags.

---
 rtl/switch_input_port_pkg.sv | 10 +
 rtl/switch_input_port_if.sv | 29 ++
 rtl/switch_input_port_bit_sync.sv | 30 +++
 rtl/switch_input_port.sv | 105 ++++++++++
 tb/tb_switch_input_port.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/switch_input_port_pkg.sv
// Shared definitions for the switch input port.
// Default sizes and the CPU I/O address of this block.
package switch_input_port_pkg;

    localparam int SW_WIDTH        = 8;
    localparam int DEBOUNCE_DEFLT  = 4;
    localparam int CNT_W_DEFLT     = 8;
    localparam logic [15:0] SW_PORT_ADDR = 16'h0004;

endpackage

// File: rtl/switch_input_port_if.sv
// CPU-side read interface of the switch input port.
// The CPU is the master; the switch port is the slave.
interface switch_input_port_if #(
    parameter int WIDTH = 8
);

    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             pending;
    logic             overrun;

    modport master (
        output rd_en,
        input  rd_data,
        input  rd_valid,
        input  pending,
        input  overrun
    );

    modport slave (
        input  rd_en,
        output rd_data,
        output rd_valid,
        output pending,
        output overrun
    );

endinterface

// File: rtl/switch_input_port_bit_sync.sv
// Two-flop synchroniser for a vector of asynchronous levels.
// Bits are synchronised independently; no logic between stages.
module bit_sync
    import switch_input_port_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two back-to-back capture stages.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/switch_input_port.sv
// Board switch input port: sync, whole-vector debounce,
// pending/overrun flags and a strobed CPU read.
module switch_input_port
    import switch_input_port_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFLT,
    parameter int CNT_W           = CNT_W_DEFLT
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           swiches,
    switch_input_port_if.slave         bus
);

    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_w;

    logic [WIDTH-1:0] cand_q,    cand_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] stable_q,  stable_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             pending_q,  pending_d;
    logic             overrun_q,  overrun_d;
    logic             upd;

    bit_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .clr (clr),
        .d_i (swiches),
        .q_o (sync_w)
    );

    // Debounce, flag and read next-state logic.
    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        upd        = 1'b0;

        if (sync_w != cand_q) begin
            cand_d = sync_w;
            cnt_d  = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (cand_q != stable_q) begin
            stable_d = cand_q;
            upd      = 1'b1;
        end

        if (upd) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end

        // A read returns the pre-update value and always
        // clears overrun; a same-edge update keeps pending.
        if (bus.rd_en) begin
            rd_data_d  = stable_q;
            rd_valid_d = 1'b1;
            overrun_d  = 1'b0;
            if (!upd) begin
                pending_d = 1'b0;
            end
        end
    end

    // State registers, cleared asynchronously by clr.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cand_q     <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Self-checking bench for switch_input_port.
// Directed table, reset corner cases, random vs model.
module tb_switch_input_port;

    localparam int DC = 4;

    logic       clk;
    logic       clr;
    logic [7:0] swiches;

    switch_input_port_if #(.WIDTH(8)) bus ();

    switch_input_port #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (8)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .swiches (swiches),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [7:0] hist[$];
    logic [7:0] m_stable;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_pend;
    logic       m_ovr;

    typedef struct {
        logic [7:0] sw;
        logic       rd;
        int         cyc;
        logic [7:0] data;
        logic       v;
        logic       p;
        logic       o;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DC + 2; i++) hist.push_back(8'h00);
        m_stable = 0;
        m_data   = 0;
        m_valid  = 0;
        m_pend   = 0;
        m_ovr    = 0;
    endtask

    // A value reaches stable once the synchronised input has
    // shown it on DC+1 consecutive edges and it differs.
    task automatic model_edge(input logic [7:0] sw,
                              input logic rd);
        logic [7:0] v;
        logic       same;
        logic       upd;
        v    = hist[DC];
        same = 1'b1;
        for (int i = 0; i <= DC; i++)
            if (hist[i] != v) same = 1'b0;
        upd = same && (v != m_stable);
        m_valid = rd;
        if (rd) m_data = m_stable;
        if (upd) begin
            m_ovr  = rd ? 1'b0 : (m_ovr | m_pend);
            m_pend = 1'b1;
            m_stable = v;
        end else if (rd) begin
            m_ovr  = 1'b0;
            m_pend = 1'b0;
        end
        hist.push_back(sw);
        void'(hist.pop_front());
    endtask

    function automatic logic [10:0] dut_out();
        return {bus.rd_data, bus.rd_valid,
                bus.pending, bus.overrun};
    endfunction

    task automatic tick(input logic [7:0] sw,
                        input logic rd);
        swiches   = sw;
        bus.rd_en = rd;
        @(posedge clk);
        model_edge(sw, rd);
        @(negedge clk);
        chk("model", 32'(dut_out()),
            32'({m_data, m_valid, m_pend, m_ovr}));
    endtask

    task automatic add(input logic [7:0] sw, input logic rd,
                       input int cyc, input logic [7:0] d,
                       input logic v, input logic p,
                       input logic o);
        vec_t e;
        e.sw = sw; e.rd = rd; e.cyc = cyc;
        e.data = d; e.v = v; e.p = p; e.o = o;
        vt.push_back(e);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        clr       = 1'b0;
        swiches   = 8'h48;
        bus.rd_en = 1'b0;
        model_reset();

        // reset / first value
        add(8'h48, 0, 6, 8'h00, 0, 0, 0);
        add(8'h48, 0, 1, 8'h00, 0, 1, 0);
        add(8'h48, 1, 1, 8'h48, 1, 0, 0);
        add(8'h48, 0, 1, 8'h48, 0, 0, 0);
        // glitch reject
        add(8'hFF, 0, 2, 8'h48, 0, 0, 0);
        add(8'h48, 0, 10, 8'h48, 0, 0, 0);
        add(8'h48, 1, 1, 8'h48, 1, 0, 0);
        // overrun
        add(8'h01, 0, 7, 8'h48, 0, 1, 0);
        add(8'h02, 0, 7, 8'h48, 0, 1, 1);
        add(8'h02, 1, 1, 8'h02, 1, 0, 0);
        // collision
        add(8'h48, 0, 7, 8'h02, 0, 1, 0);
        add(8'h48, 1, 1, 8'h48, 1, 0, 0);
        add(8'h10, 0, 6, 8'h48, 0, 0, 0);
        add(8'h10, 1, 1, 8'h48, 1, 1, 0);
        add(8'h10, 1, 1, 8'h10, 1, 0, 0);
        // back-to-back reads
        add(8'h3C, 0, 8, 8'h10, 0, 1, 0);
        add(8'h3C, 1, 1, 8'h3C, 1, 0, 0);
        add(8'h3C, 1, 1, 8'h3C, 1, 0, 0);
        add(8'h3C, 1, 1, 8'h3C, 1, 0, 0);
        add(8'h3C, 0, 1, 8'h3C, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset_hold", 32'(dut_out()), 32'h0);
        clr = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            for (int c = 0; c < vt[i].cyc; c++)
                tick(vt[i].sw, vt[i].rd);
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({vt[i].data, vt[i].v, vt[i].p, vt[i].o}));
        end

        // async reset mid-debounce
        repeat (4) tick(8'hAA, 0);
        #2;
        clr = 1'b0;
        #1;
        chk("async_clr", 32'(dut_out()), 32'h0);
        model_reset();
        @(negedge clk);
        chk("clr_held", 32'(dut_out()), 32'h0);
        clr = 1'b1;
        repeat (6) tick(8'hAA, 0);
        chk("aa_not_yet", 32'(bus.pending), 32'd0);
        tick(8'hAA, 0);
        chk("aa_pending", 32'(bus.pending), 32'd1);
        tick(8'hAA, 1);
        chk("aa_read", 32'({bus.rd_data, bus.rd_valid}),
            32'({8'hAA, 1'b1}));
        tick(8'hAA, 0);
        chk("aa_valid_drop", 32'(bus.rd_valid), 32'd0);

        // random against the model
        begin
            logic [7:0] sw;
            int         hold;
            sw = 8'hAA;
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 3) != 0)
                    sw = 8'($urandom());
                hold = $urandom_range(1, 9);
                for (int j = 0; j < hold; j++)
                    tick(sw, ($urandom_range(0, 4) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
